// File: rtl/bitserial_alu_seq.sv
// Bit-serial ALU sequencer: walks an external single-bit ALU slice across a
// WIDTH-bit operation one bit per clock, LSB first. It keeps the carry between
// cycles, runs the SLT less/set feedback pass, and registers result and flags.
module bitserial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_addsub,
    output logic             slice_less,
    output logic [2:0]       slice_control,
    input  logic             slice_result,
    input  logic             slice_cout,
    input  logic             slice_set
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SLT_FIX,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             sign_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    logic             last_bit;
    logic             sub_op;
    logic             arith_op;
    logic             start_sub;
    logic [WIDTH-1:0] result_run_next;

    assign last_bit  = (idx == IW'(WIDTH - 1));
    assign sub_op    = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign arith_op  = sub_op || (op_q == OP_ADD);
    assign start_sub = (alu_control == OP_SUB) || (alu_control == OP_SLT);

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every register samples
        // pre-edge values, independent of the order of statements.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path through
        // the case can leave it unassigned and infer a latch.
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_RUN;
            S_RUN:     if (last_bit) state_next = (op_q == OP_SLT) ? S_SLT_FIX : S_DONE;
            S_SLT_FIX: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Slice drive: purely from registered state, so there is no combinational
    // loop through the external slice.
    always_comb begin
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_cin     = 1'b0;
        slice_addsub  = 1'b0;
        slice_less    = 1'b0;
        slice_control = 3'd0;
        case (state)
            S_RUN: begin
                slice_a       = a_q[idx];
                slice_b       = b_q[idx];
                slice_cin     = carry;
                slice_addsub  = sub_op;
                slice_control = (op_q == OP_SLT) ? OP_SUB : op_q;
            end
            S_SLT_FIX: begin
                slice_a       = a_q[0];
                slice_b       = b_q[0];
                slice_less    = sign_q ^ ovf_q;
                slice_control = OP_SLT;
            end
            default: ;
        endcase
    end

    // Result with the current slice bit merged in at the active bit position.
    always_comb begin
        result_run_next      = result_q;
        result_run_next[idx] = slice_result;
    end

    // Operand capture, carry chain, result assembly and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'd0;
            idx      <= '0;
            carry    <= 1'b0;
            sign_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= alu_control;
                        idx      <= '0;
                        carry    <= start_sub;
                        result_q <= '0;
                    end
                end
                S_RUN: begin
                    result_q <= result_run_next;
                    carry    <= slice_cout;
                    if (last_bit) begin
                        idx    <= '0;
                        ovf_q  <= arith_op ? (carry ^ slice_cout) : 1'b0;
                        sign_q <= slice_set;
                        // SLT gets its zero flag after the fix-up pass.
                        if (op_q != OP_SLT) zero_q <= (result_run_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_SLT_FIX: begin
                    result_q <= {{(WIDTH-1){1'b0}}, slice_result};
                    zero_q   <= ~slice_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_alu_seq.sv
// Directed bench for bitserial_alu_seq at WIDTH=8, with a behavioural model of
// the single-bit ALU slice closing the loop around the sequencer.
module tb_bitserial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic [2:0]   alu_control;
    logic         busy, done, zero, overflow;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_cin, slice_addsub, slice_less;
    logic [2:0]   slice_control;
    logic         slice_result, slice_cout, slice_set;

    int checks = 0;
    int errors = 0;

    bitserial_alu_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .a             (a),
        .b             (b),
        .alu_control   (alu_control),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .zero          (zero),
        .overflow      (overflow),
        .slice_a       (slice_a),
        .slice_b       (slice_b),
        .slice_cin     (slice_cin),
        .slice_addsub  (slice_addsub),
        .slice_less    (slice_less),
        .slice_control (slice_control),
        .slice_result  (slice_result),
        .slice_cout    (slice_cout),
        .slice_set     (slice_set)
    );

    always #5 clk = ~clk;

    // Single-bit ALU slice model.
    logic bx, m_sum;
    always_comb begin
        bx         = slice_b ^ slice_addsub;
        m_sum      = slice_a ^ bx ^ slice_cin;
        slice_cout = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);
        slice_set  = m_sum;
        case (slice_control)
            3'd0:    slice_result = slice_a & slice_b;
            3'd1:    slice_result = slice_a | slice_b;
            3'd2:    slice_result = m_sum;
            3'd3:    slice_result = ~(slice_a | slice_b);
            3'd4:    slice_result = slice_a ^ slice_b;
            3'd5:    slice_result = ~(slice_a & slice_b);
            3'd6:    slice_result = m_sum;
            default: slice_result = slice_less;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] slice_bus();
        return {slice_a, slice_b, slice_cin, slice_addsub, slice_less, slice_control};
    endfunction

    // Issue one operation and follow it to done. Cycle 0 is the cycle in
    // which start is sampled; done is expected in cycle exp_lat. If glitch
    // is nonzero, a different operation is requested in that cycle.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic ez, input logic eo,
                         input int exp_lat, input int glitch);
        int cyc;
        @(negedge clk);
        a = av; b = bv; alu_control = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_cin0"}, slice_cin, (op == 3'd6 || op == 3'd7));
        check({tag, "_ctl0"}, slice_control, (op == 3'd7) ? 3'd6 : op);
        while (!done && cyc < 20) begin
            if (glitch != 0 && cyc == glitch) begin
                a = ~av; b = ~bv; alu_control = 3'd4; start = 1'b1;
            end
            if (op == 3'd7 && cyc == W + 1) begin
                check({tag, "_fixctl"}, slice_control, 3'd7);
                check({tag, "_less"}, slice_less, er[0]);
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, result, er);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_ovf"}, overflow, eo);
        @(negedge clk);
        check({tag, "_idle"}, {busy, done}, 2'b00);
        check({tag, "_hold"}, {result, zero, overflow}, {er, ez, eo});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; alu_control = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_flags", {busy, done, zero, overflow}, 4'b0000);
        check("rst_result", result, 8'h00);
        check("rst_slice", slice_bus(), 8'h00);
        reset = 1'b0;

        do_op("add_ovf",  3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, W + 1, 0);
        do_op("sub_zero", 3'd6, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, W + 1, 0);
        do_op("slt_neg",  3'd7, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, W + 2, 0);
        do_op("slt_pos",  3'd7, 8'h01, 8'h80, 8'h00, 1'b1, 1'b1, W + 2, 0);

        // Reset while bit 3 of an ADD is on the slice.
        @(negedge clk);
        a = 8'h5A; b = 8'h33; alu_control = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_flags", {busy, done, zero, overflow}, 4'b0000);
        check("mid_rst_result", result, 8'h00);
        check("mid_rst_slice", slice_bus(), 8'h00);
        reset = 1'b0;

        do_op("add_fresh", 3'd2, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, W + 1, 0);
        do_op("nor",  3'd3, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, W + 1, 0);
        do_op("xor",  3'd4, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, W + 1, 0);
        do_op("nand", 3'd5, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, W + 1, 0);
        do_op("and",  3'd0, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, W + 1, 0);
        do_op("or",   3'd1, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0, W + 1, 0);
        do_op("ignore_start", 3'd2, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, W + 1, 3);

        // Back-to-back with start held high throughout.
        begin
            int cyc;
            @(negedge clk);
            a = 8'h10; b = 8'h20; alu_control = 3'd2; start = 1'b1;
            cyc = 0;
            while (!done && cyc < 20) begin @(negedge clk); cyc++; end
            check("b2b1_lat", cyc, W + 1);
            check("b2b1_res", {result, overflow}, {8'h30, 1'b0});
            a = 8'h10; b = 8'h20; alu_control = 3'd6;
            @(negedge clk);
            cyc++;
            check("b2b_gap_idle", busy, 0);
            @(negedge clk);
            cyc++;
            check("b2b2_accepted", busy, 1);
            while (!done && cyc < 40) begin @(negedge clk); cyc++; end
            start = 1'b0;
            check("b2b2_lat", cyc, 2 * (W + 1) + 1);
            check("b2b2_res", {result, zero, overflow}, {8'hF0, 1'b0, 1'b0});
            @(negedge clk);
            check("b2b2_idle", {busy, done}, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
